// File: rtl/eyearch_pkg.sv
// Shared widths, types and constants for the register file slice.
package eyearch_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    typedef logic [15:0] data_t;
    typedef logic [2:0]  reg_idx_t;

    localparam reg_idx_t REG_ZERO = 3'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending scoreboard: tracks outstanding producers and raises stall
// on RAW/WAW hazards, with a completing writeback satisfying hazards in the same cycle.
module reg_scoreboard
    import eyearch_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = eyearch_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                use_rs1,
    input  logic [ADDR_W-1:0]   rs1_addr,
    input  logic                use_rs2,
    input  logic [ADDR_W-1:0]   rs2_addr,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending_vec
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [NUM_REGS-1:0] eff;

    always_comb begin
        eff = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            eff[i] = pending[i] && !(wb_en && (wb_addr == ADDR_W'(i)));
        end
    end

    // eff[0] is forced low above, so r0 terms are masked automatically.
    always_comb begin
        stall = issue_en && ((use_rs1 && eff[rs1_addr]) ||
                             (use_rs2 && eff[rs2_addr]) ||
                             eff[issue_rd]);
    end

    // Clear first, then set: a new producer issued on the same edge wins.
    always_comb begin
        pending_nxt = pending;
        if (wb_en) begin
            pending_nxt[wb_addr] = 1'b0;
        end
        if (issue_en && !stall && (issue_rd != ADDR_W'(REG_ZERO))) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign pending_vec = pending;

    a_r0_never_pending: assert property (@(posedge clk) disable iff (!rst_n) !pending[0]);
    a_stall_holds_scoreboard: assert property (@(posedge clk) disable iff (!rst_n)
        (stall && !wb_en) |=> (pending == $past(pending)));

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file fed by the writeback mux: one write port,
// two bypassed combinational read ports and a hazard scoreboard for decode.
module reg_file_wb
    import eyearch_pkg::*;
#(
    parameter int unsigned DATA_W   = eyearch_pkg::DATA_W,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = eyearch_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic [ADDR_W-1:0]   rs1_addr,
    input  logic [ADDR_W-1:0]   rs2_addr,
    output logic [DATA_W-1:0]   rs1_data,
    output logic [DATA_W-1:0]   rs2_data,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                use_rs1,
    input  logic                use_rs2,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending_vec
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wb_live;

    assign wb_live = wb_en && (wb_addr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Write-through bypass so decode sees the committing value in the same cycle.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != ADDR_W'(REG_ZERO)) begin
            if (wb_live && (wb_addr == rs1_addr)) begin
                rs1_data = wb_data;
            end else begin
                rs1_data = regs[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != ADDR_W'(REG_ZERO)) begin
            if (wb_live && (wb_addr == rs2_addr)) begin
                rs2_data = wb_data;
            end else begin
                rs2_data = regs[rs2_addr];
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .use_rs1     (use_rs1),
        .rs1_addr    (rs1_addr),
        .use_rs2     (use_rs2),
        .rs2_addr    (rs2_addr),
        .stall       (stall),
        .pending_vec (pending_vec)
    );

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb with hand-computed expectations.
module tb_reg_file_wb;

    logic        clk;
    logic        rst_n;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [2:0]  rs1_addr;
    logic [2:0]  rs2_addr;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic        issue_en;
    logic [2:0]  issue_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        stall;
    logic [7:0]  pending_vec;

    int unsigned n_pass;
    int unsigned n_total;

    reg_file_wb #(
        .DATA_W   (16),
        .NUM_REGS (8),
        .ADDR_W   (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .use_rs1     (use_rs1),
        .use_rs2     (use_rs2),
        .stall       (stall),
        .pending_vec (pending_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst_n    = 1'b0;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        rs1_addr = '0;
        rs2_addr = '0;
        issue_en = 1'b0;
        issue_rd = '0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        #12;
        check("reset_rs1", 32'(rs1_data), 32'h0);
        check("reset_pending", 32'(pending_vec), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        rst_n = 1'b1;
        tick();

        // Write r3 with same-cycle bypass, then read from the array.
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'hBEEF; rs1_addr = 3'd3; rs2_addr = 3'd3;
        #1;
        check("bypass_rs1", 32'(rs1_data), 32'hBEEF);
        check("bypass_rs2", 32'(rs2_data), 32'hBEEF);
        tick();
        wb_en = 1'b0;
        #1;
        check("readback_rs1", 32'(rs1_data), 32'hBEEF);
        check("readback_pending", 32'(pending_vec), 32'h0);

        // r0 is hardwired zero, even when targeted by writeback or issue.
        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'h1234; rs1_addr = 3'd0;
        issue_en = 1'b1; issue_rd = 3'd0;
        #1;
        check("r0_same_cycle", 32'(rs1_data), 32'h0);
        check("r0_issue_stall", 32'(stall), 32'h0);
        tick();
        wb_en = 1'b0; issue_en = 1'b0;
        #1;
        check("r0_next_cycle", 32'(rs1_data), 32'h0);
        check("r0_pending", 32'(pending_vec), 32'h0);

        // RAW on r5.
        issue_en = 1'b1; issue_rd = 3'd5;
        #1;
        check("raw_issue_stall", 32'(stall), 32'h0);
        tick();
        issue_en = 1'b0;
        #1;
        check("raw_pending_set", 32'(pending_vec), 32'h20);
        issue_en = 1'b1; issue_rd = 3'd1; use_rs1 = 1'b1; rs1_addr = 3'd5;
        #1;
        check("raw_stall", 32'(stall), 32'h1);
        tick();
        check("raw_hold_pending", 32'(pending_vec), 32'h20);
        check("raw_hold_stall", 32'(stall), 32'h1);
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h00A5;
        #1;
        check("raw_wb_stall", 32'(stall), 32'h0);
        check("raw_wb_bypass", 32'(rs1_data), 32'h00A5);
        tick();
        wb_en = 1'b0; issue_en = 1'b0; use_rs1 = 1'b0;
        #1;
        check("raw_clear_and_set", 32'(pending_vec), 32'h02);
        check("raw_array_r5", 32'(rs1_data), 32'h00A5);

        // WAW on r2 and same-edge set/clear.
        issue_en = 1'b1; issue_rd = 3'd2;
        #1;
        check("waw_first_issue", 32'(stall), 32'h0);
        tick();
        check("waw_pending_set", 32'(pending_vec), 32'h06);
        check("waw_stall", 32'(stall), 32'h1);
        tick();
        check("waw_hold_pending", 32'(pending_vec), 32'h06);
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h2222;
        #1;
        check("waw_wb_stall", 32'(stall), 32'h0);
        tick();
        issue_en = 1'b0; wb_addr = 3'd1; wb_data = 16'h1111;
        #1;
        check("set_wins", 32'(pending_vec), 32'h06);
        tick();
        wb_addr = 3'd2;
        #1;
        check("clear_r1", 32'(pending_vec), 32'h04);
        tick();
        wb_en = 1'b0;
        #1;
        check("clear_r2", 32'(pending_vec), 32'h00);

        // Writeback to a non-pending register.
        wb_en = 1'b1; wb_addr = 3'd6; wb_data = 16'h7FFF;
        issue_en = 1'b1; issue_rd = 3'd4;
        #1;
        check("unmatched_stall", 32'(stall), 32'h0);
        tick();
        wb_en = 1'b0; issue_en = 1'b0; rs2_addr = 3'd6;
        #1;
        check("unmatched_pending", 32'(pending_vec), 32'h10);
        check("unmatched_data", 32'(rs2_data), 32'h7FFF);

        // rs2 hazard, and use_rs2 gating.
        issue_en = 1'b1; issue_rd = 3'd7; use_rs2 = 1'b1; rs2_addr = 3'd4;
        #1;
        check("rs2_stall", 32'(stall), 32'h1);
        use_rs2 = 1'b0;
        #1;
        check("rs2_unused", 32'(stall), 32'h0);
        issue_en = 1'b0;

        // Asynchronous reset mid-operation, away from any clock edge.
        rs1_addr = 3'd3;
        @(negedge clk);
        check("pre_reset_r3", 32'(rs1_data), 32'hBEEF);
        rst_n = 1'b0;
        #1;
        check("async_rs1", 32'(rs1_data), 32'h0);
        check("async_rs2", 32'(rs2_data), 32'h0);
        check("async_pending", 32'(pending_vec), 32'h0);
        issue_en = 1'b1; issue_rd = 3'd4;
        #1;
        check("async_stall", 32'(stall), 32'h0);
        issue_en = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Architectural register file that consumes the writeback mux result and commits it to one of NUM_REGS 16-bit registers.
- Two combinational read ports serve the decode stage.
- A per-register pending scoreboard raises stall on read-after-write and write-after-write hazards against outstanding results.
- Sits directly downstream of the writeback select mux and upstream of decode/operand fetch.

Parameters:
- DATA_W, 16, register and datapath width.
- NUM_REGS, 8, number of architectural registers; r0 is hardwired zero.
- ADDR_W, 3, register index width, equal to $clog2(NUM_REGS).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_en  in  1  commit wb_data to wb_addr this cycle.
- wb_addr  in  ADDR_W  destination register of the commit.
- wb_data  in  DATA_W  writeback value (mux output).
- rs1_addr  in  ADDR_W  read port 1 index.
- rs2_addr  in  ADDR_W  read port 2 index.
- rs1_data  out  DATA_W  read port 1 value (bypassed).
- rs2_data  out  DATA_W  read port 2 value (bypassed).
- issue_en  in  1  decode wants to issue an instruction that writes issue_rd.
- issue_rd  in  ADDR_W  destination of the issuing instruction.
- use_rs1  in  1  issuing instruction reads rs1.
- use_rs2  in  1  issuing instruction reads rs2.
- stall  out  1  hazard; decode must hold the instruction.
- pending_vec  out  NUM_REGS  scoreboard state, for debug and assertions.

Behaviour:
- Reset: asynchronous on rst_n low. All registers clear to 0 and pending_vec clears to 0. With all pending bits clear, stall is 0; rs*_data read 0.
- Write: on the rising clk edge with wb_en=1 and wb_addr!=0, regs[wb_addr] <= wb_data. Writes to r0 are discarded.
- Read: rs1_data and rs2_data are combinational, zero-latency.
  - r0 always reads 0.
  - Bypass: if wb_en=1 and wb_addr==rsN_addr!=0, rsN_data = wb_data in the same cycle (write-through).
  - Otherwise rsN_data = regs[rsN_addr].
- Pending clear: on the edge with wb_en=1, the bit pending[wb_addr] clears.
- Pending set:
  - On the edge with issue_en=1, stall=0 and issue_rd!=0, the bit pending[issue_rd] sets.
  - Issue to r0 never sets a bit.
- Set and clear on the same register in the same edge: set wins, because a new producer is outstanding.
- Effective-pending for hazard checks: eff[i] = pending[i] && !(wb_en && wb_addr==i). A completing writeback satisfies a hazard in the same cycle, consistent with the bypass.
- stall = issue_en && ( (use_rs1 && eff[rs1_addr]) || (use_rs2 && eff[rs2_addr]) || eff[issue_rd] ), with terms indexing r0 masked to 0.
  - stall is purely combinational.
  - The scoreboard is not modified while stall=1.
- Writeback to a register that is not pending is legal: the data is written, the bit stays 0, and no error is raised.
- Reset mid-operation discards all outstanding pending bits. Producers still in flight after reset must be flushed by the pipeline.
- No internal latches. The register array and scoreboard are flops; the read, bypass and stall logic is always_comb.

Decomposition:
- Shared package eyearch_pkg holds:
  - DATA_W and ADDR_W constants.
  - typedef data_t (logic [15:0]) and reg_idx_t (logic [2:0]).
  - localparam REG_ZERO = 3'd0.
- Natural sub-module: reg_scoreboard. It owns pending_vec, the eff[] computation and the stall equation.
- reg_file_wb instantiates reg_scoreboard and keeps the array, write port and bypass muxes.

Test Plan:
- Reset then read: rst_n low mid-test after writes -> all rs*_data = 0x0000, pending_vec = 0, stall = 0 immediately, asynchronously.
- Write and read back: wb_en=1, wb_addr=3, wb_data=0xBEEF, rs1_addr=3 in the same cycle -> rs1_data=0xBEEF (bypass). Next cycle with wb_en=0 -> still 0xBEEF.
- r0 protection: wb_en=1, wb_addr=0, wb_data=0x1234 -> rs1_addr=0 reads 0x0000 in the same and following cycles; pending_vec[0] never sets.
- RAW hazard:
  - Issue issue_rd=5 -> pending_vec=8'b0010_0000.
  - Next cycle: issue with use_rs1=1, rs1_addr=5 -> stall=1, scoreboard unchanged.
  - Then wb_en=1, wb_addr=5, wb_data=0x00A5 -> stall=0 the same cycle, rs1_data=0x00A5, pending[5] clears.
- WAW and same-edge set/clear:
  - With pending[2]=1, issue with issue_rd=2 and no writeback -> stall=1.
  - Issue with issue_rd=2 while wb_en=1, wb_addr=2 -> stall=0, and pending[2] remains 1 after the edge.
- Unmatched writeback: wb_en=1, wb_addr=6, wb_data=0x7FFF with pending[6]=0 -> value written, pending_vec unchanged, no stall.
